multicycle_control: RTL



---
 rtl/multicycle_pkg.sv | 53 +++++
 rtl/multicycle_control_ula_decoder.sv | 29 ++
 rtl/multicycle_control.sv | 137 +++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control unit:
// FSM states, opcode/funct values, ULA operations and datapath select codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b101;

    // ula_op: what the FSM asks of the ULA decoder
    localparam logic [1:0] ULAOP_ADD   = 2'b00;
    localparam logic [1:0] ULAOP_SUB   = 2'b01;
    localparam logic [1:0] ULAOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_ula_decoder.sv
// Combinational ULA control decoder: fixed add/sub requests from the FSM,
// or an R-type operation selected by the Funct field.
module ula_decoder
    import multicycle_pkg::*;
(
    input  logic [5:0] i_funct,
    input  logic [1:0] i_ula_op,
    output logic [2:0] o_ula_control
);

    always_comb begin
        o_ula_control = ULA_ADD;
        case (i_ula_op)
            ULAOP_SUB: o_ula_control = ULA_SUB;
            ULAOP_FUNCT: begin
                case (i_funct)
                    FUNCT_ADD: o_ula_control = ULA_ADD;
                    FUNCT_SUB: o_ula_control = ULA_SUB;
                    FUNCT_AND: o_ula_control = ULA_AND;
                    FUNCT_OR:  o_ula_control = ULA_OR;
                    FUNCT_SLT: o_ula_control = ULA_SLT;
                    default:   o_ula_control = ULA_ADD;
                endcase
            end
            default: o_ula_control = ULA_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle datapath; drives all mux selects and
// write enables. Only ULAControl (EXECUTE) and PCEn (BEQ) see live inputs.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter bit ENABLE_JUMP = 1'b1,
    parameter int STATE_W     = 4     // must be >= 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Z,
    output logic [2:0]         ULAControl,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     r_state;
    state_t     w_state_next;
    state_t     w_state_cur;
    logic [1:0] w_ula_op;
    logic       w_pc_write;
    logic       w_branch;

    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_state_next;
    end

    // While reset is held the outputs look like FETCH with every enable off.
    assign w_state_cur = reset ? FETCH : r_state;

    always_comb begin
        w_state_next = FETCH;
        w_ula_op     = ULAOP_ADD;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REGB;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        MemWrite     = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        PCSrc        = PCSRC_ULA;
        case (w_state_cur)
            FETCH: begin
                IRWrite      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                w_pc_write   = 1'b1;
                w_state_next = DECODE;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                case (Op)
                    OP_LW, OP_SW: w_state_next = MEMADR;
                    OP_RTYPE:     w_state_next = EXECUTE;
                    OP_BEQ:       w_state_next = BEQ;
                    OP_ADDI:      w_state_next = ADDIEX;
                    OP_J:         w_state_next = ENABLE_JUMP ? JUMP : FETCH;
                    default:      w_state_next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                w_state_next = (Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD         = 1'b1;
                w_state_next = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA      = 1'b1;
                w_ula_op     = ULAOP_FUNCT;
                w_state_next = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA  = 1'b1;
                w_ula_op = ULAOP_SUB;
                PCSrc    = PCSRC_ULAOUT;
                w_branch = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                w_state_next = ADDIWB;
            end
            ADDIWB:  RegWrite = 1'b1;
            JUMP: begin
                PCSrc      = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: w_state_next = FETCH;
        endcase
        if (reset) begin
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            w_pc_write = 1'b0;
            w_branch   = 1'b0;
        end
    end

    assign PCEn      = w_pc_write | (w_branch & Z);
    assign state_dbg = reset ? '0 : STATE_W'(r_state);

    ula_decoder u_ula_decoder (
        .i_funct       (Funct),
        .i_ula_op      (w_ula_op),
        .o_ula_control (ULAControl)
    );

endmodule
